// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the 8-bit synchronous FIFO and serializes
// each one as a UART frame (start, 8 data bits LSB first, optional parity,
// one stop bit) on a registered, idle-high tx line.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] frames_sent
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_PAR   = 3'd5,
    S_STOP  = 3'd6
  } state_t;

  // Last baud count of a bit period; a bit boundary happens only here.
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 32'd1);
  // PARITY = 3 falls back to no parity bit.
  localparam logic PAR_EN  = (PARITY == 32'd1) || (PARITY == 32'd2);
  localparam logic PAR_ODD = (PARITY == 32'd2);

  // Even parity of the byte, inverted for odd parity.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    calc_parity = (^data) ^ odd;
  endfunction

  state_t      state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shreg_q;
  logic        par_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] frames_sent_q;

  logic        baud_last_s;
  logic [15:0] baud_d;
  logic [15:0] frames_sent_d;

  // Bit-boundary detect, next baud count and next frame count.
  always_comb begin
    baud_last_s   = (baud_q == BAUD_LAST);
    baud_d        = baud_q + 16'd1;
    frames_sent_d = frames_sent_q + 16'd1;
  end

  // Frame sequencer: state, baud/bit counters, shift register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      baud_q        <= 16'd0;
      bit_q         <= 3'd0;
      shreg_q       <= 8'd0;
      par_q         <= 1'b0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frames_sent_q <= 16'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          baud_q <= 16'd0;
          bit_q  <= 3'd0;
          tx_q   <= 1'b1;
          if (tx_en && !fifo_empty) begin
            state_q <= S_POP;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        // The pop strobe is decoded from this state; buf_out is valid next cycle.
        S_POP: begin
          state_q <= S_LOAD;
        end

        S_LOAD: begin
          shreg_q <= fifo_data;
          par_q   <= calc_parity(fifo_data, PAR_ODD);
          tx_q    <= 1'b0;
          baud_q  <= 16'd0;
          state_q <= S_START;
        end

        S_START: begin
          if (baud_last_s) begin
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            tx_q    <= shreg_q[0];
            shreg_q <= {1'b0, shreg_q[7:1]};
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_d;
          end
        end

        S_DATA: begin
          if (baud_last_s) begin
            baud_q <= 16'd0;
            if (bit_q == 3'd7) begin
              bit_q <= 3'd0;
              if (PAR_EN) begin
                tx_q    <= par_q;
                state_q <= S_PAR;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shreg_q[0];
              shreg_q <= {1'b0, shreg_q[7:1]};
            end
          end else begin
            baud_q <= baud_d;
          end
        end

        S_PAR: begin
          if (baud_last_s) begin
            baud_q  <= 16'd0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_d;
          end
        end

        S_STOP: begin
          if (baud_last_s) begin
            baud_q        <= 16'd0;
            done_q        <= 1'b1;
            frames_sent_q <= frames_sent_d;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end else begin
            baud_q <= baud_d;
          end
        end

        default: begin
          state_q <= S_IDLE;
          baud_q  <= 16'd0;
          bit_q   <= 3'd0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en  = (state_q == S_POP);
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;
  assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: three instances (no, even, odd parity) each fed
// by a small FIFO model; the expected tx line is built per cycle from the
// UART framing rules and compared against the recorded line.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en      [3] = '{1'b0, 1'b0, 1'b0};
  logic        fifo_empty [3];
  logic [7:0]  fifo_data  [3] = '{8'h00, 8'h00, 8'h00};
  logic        rd_en      [3];
  logic        tx         [3];
  logic        busy       [3];
  logic        tx_done    [3];
  logic [15:0] frames     [3];

  logic [7:0]  mem  [3][16];
  int          wr_p [3] = '{0, 0, 0};
  int          rd_p [3] = '{0, 0, 0};

  int   errors = 0;
  int   checks = 0;
  logic exp_q [$];
  logic act_q [$];
  int   rd_cnt, done_cnt, done_idx, busy_cnt;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY(0)) u_none (
    .clk(clk), .rst(rst), .tx_en(tx_en[0]), .fifo_empty(fifo_empty[0]),
    .fifo_data(fifo_data[0]), .fifo_rd_en(rd_en[0]), .tx(tx[0]),
    .busy(busy[0]), .tx_done(tx_done[0]), .frames_sent(frames[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY(1)) u_even (
    .clk(clk), .rst(rst), .tx_en(tx_en[1]), .fifo_empty(fifo_empty[1]),
    .fifo_data(fifo_data[1]), .fifo_rd_en(rd_en[1]), .tx(tx[1]),
    .busy(busy[1]), .tx_done(tx_done[1]), .frames_sent(frames[1]));

  fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY(2)) u_odd (
    .clk(clk), .rst(rst), .tx_en(tx_en[2]), .fifo_empty(fifo_empty[2]),
    .fifo_data(fifo_data[2]), .fifo_rd_en(rd_en[2]), .tx(tx[2]),
    .busy(busy[2]), .tx_done(tx_done[2]), .frames_sent(frames[2]));

  // FIFO model empty flags.
  always_comb begin
    for (int i = 0; i < 3; i++) fifo_empty[i] = (wr_p[i] == rd_p[i]);
  end

  // FIFO model read side: registered buf_out, one cycle after a qualified pop.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_en[i] && (rd_p[i] != wr_p[i])) begin
        fifo_data[i] <= mem[i][rd_p[i] % 16];
        rd_p[i]      <= rd_p[i] + 1;
      end
    end
  end

  task automatic push(input int i, input logic [7:0] b);
    mem[i][wr_p[i] % 16] = b;
    wr_p[i] = wr_p[i] + 1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) tx_en[i] = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic clear_rec();
    exp_q.delete();
    act_q.delete();
    rd_cnt   = 0;
    done_cnt = 0;
    done_idx = -1;
    busy_cnt = 0;
  endtask

  // Expected line: n idle-high cycles.
  task automatic model_idle(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endtask

  // Expected line for one frame: start, data LSB first, parity, stop, N cycles each.
  task automatic model_frame(input logic [7:0] b, input int par);
    logic bits [$];
    int   ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) begin
      bits.push_back(b[k]);
      ones = ones + int'(b[k]);
    end
    if (par == 1) bits.push_back((ones % 2) == 1);
    else if (par == 2) bits.push_back((ones % 2) == 0);
    bits.push_back(1'b1);
    foreach (bits[k]) repeat (N) exp_q.push_back(bits[k]);
  endtask

  // Record n cycles of instance i, sampled 1 ns after each rising edge.
  task automatic record(input int i, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      act_q.push_back(tx[i]);
      if (rd_en[i] === 1'b1) rd_cnt++;
      if (busy[i] === 1'b1) busy_cnt++;
      if (tx_done[i] === 1'b1) begin
        if (done_idx < 0) done_idx = act_q.size() - 1;
        done_cnt++;
      end
    end
  endtask

  function automatic int first_mismatch();
    if (act_q.size() != exp_q.size()) return 0;
    foreach (exp_q[k]) if (act_q[k] !== exp_q[k]) return k;
    return -1;
  endfunction

  task automatic test_reset();
    int mm;
    push(0, 8'hA5);
    rst = 1'b1;
    tick(3);
    checks++; if (tx[0] !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy[0]); end
    checks++; if (tx_done[0] !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", tx_done[0]); end
    checks++; if (frames[0] !== 16'd0) begin errors++; $display("FAIL reset_frames: got %0d expected 0", frames[0]); end
    rst = 1'b0;
    clear_rec();
    model_idle(12);
    record(0, exp_q.size());
    mm = first_mismatch();
    checks++; if (mm != -1) begin errors++; $display("FAIL reset_idle_line: cycle %0d got %b expected %b", mm, act_q[mm], exp_q[mm]); end
    checks++; if (rd_cnt != 0) begin errors++; $display("FAIL reset_no_pop: got %0d pops expected 0", rd_cnt); end
    checks++; if (busy_cnt != 0) begin errors++; $display("FAIL reset_no_busy: got %0d busy cycles expected 0", busy_cnt); end
    checks++; if (frames[0] !== 16'd0) begin errors++; $display("FAIL reset_frames_hold: got %0d expected 0", frames[0]); end
  endtask

  task automatic test_single_byte();
    int mm;
    clear_rec();
    model_idle(2);
    model_frame(8'hA5, 0);
    model_idle(4);
    tx_en[0] = 1'b1;
    record(0, exp_q.size());
    tx_en[0] = 1'b0;
    mm = first_mismatch();
    checks++; if (mm != -1) begin errors++; $display("FAIL single_line: cycle %0d got %b expected %b", mm, act_q[mm], exp_q[mm]); end
    checks++; if (act_q[2] !== 1'b0 || act_q[1] !== 1'b1) begin errors++; $display("FAIL single_start_latency: got %b%b expected 10", act_q[1], act_q[2]); end
    checks++; if (rd_cnt != 1) begin errors++; $display("FAIL single_pop_count: got %0d expected 1", rd_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_idx != 2 + 10 * N) begin errors++; $display("FAIL single_done_time: got %0d expected %0d", done_idx, 2 + 10 * N); end
    checks++; if (busy_cnt != 2 + 10 * N) begin errors++; $display("FAIL single_busy_cycles: got %0d expected %0d", busy_cnt, 2 + 10 * N); end
    checks++; if (frames[0] !== 16'd1) begin errors++; $display("FAIL single_frames: got %0d expected 1", frames[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy[0]); end
  endtask

  task automatic test_parity();
    int         mm;
    logic [7:0] b;
    logic       exp_par;
    for (int p = 1; p <= 2; p++) begin
      for (int n = 0; n < 2; n++) begin
        b = (n == 0) ? 8'h07 : 8'($urandom_range(0, 255));
        clear_rec();
        model_idle(2);
        model_frame(b, p);
        model_idle(3);
        push(p, b);
        tx_en[p] = 1'b1;
        record(p, exp_q.size());
        tx_en[p] = 1'b0;
        mm = first_mismatch();
        checks++; if (mm != -1) begin errors++; $display("FAIL parity%0d_line byte %h: cycle %0d got %b expected %b", p, b, mm, act_q[mm], exp_q[mm]); end
        checks++; if (done_idx - 2 != 11 * N) begin errors++; $display("FAIL parity%0d_frame_len: got %0d expected %0d", p, done_idx - 2, 11 * N); end
        checks++; if (rd_cnt != 1 || done_cnt != 1) begin errors++; $display("FAIL parity%0d_counts: got pops %0d dones %0d expected 1 1", p, rd_cnt, done_cnt); end
        if (n == 0) begin
          exp_par = (p == 1) ? 1'b1 : 1'b0;
          checks++; if (act_q[2 + 9 * N] !== exp_par) begin errors++; $display("FAIL parity%0d_bit_07: got %b expected %b", p, act_q[2 + 9 * N], exp_par); end
        end
      end
      checks++; if (frames[p] !== 16'd2) begin errors++; $display("FAIL parity%0d_frames: got %0d expected 2", p, frames[p]); end
    end
  endtask

  task automatic test_back_to_back();
    int         mm;
    int         cnt;
    logic [7:0] b;
    do_reset();
    clear_rec();
    model_idle(2);
    for (int k = 1; k <= 3; k++) begin
      push(0, 8'(k));
      if (k > 1) model_idle(3);
      model_frame(8'(k), 0);
    end
    model_idle(4);
    tx_en[0] = 1'b1;
    record(0, exp_q.size());
    mm = first_mismatch();
    checks++; if (mm != -1) begin errors++; $display("FAIL b2b_line: cycle %0d got %b expected %b", mm, act_q[mm], exp_q[mm]); end
    checks++; if (rd_cnt != 3 || done_cnt != 3) begin errors++; $display("FAIL b2b_counts: got pops %0d dones %0d expected 3 3", rd_cnt, done_cnt); end
    checks++; if (frames[0] !== 16'd3) begin errors++; $display("FAIL b2b_frames: got %0d expected 3", frames[0]); end
    checks++; if (busy[0] !== 1'b0 || fifo_empty[0] !== 1'b1) begin errors++; $display("FAIL b2b_idle: got busy %b empty %b expected 0 1", busy[0], fifo_empty[0]); end
    tx_en[0] = 1'b0;
    tick(1);
    cnt = $urandom_range(2, 5);
    clear_rec();
    model_idle(2);
    for (int k = 0; k < cnt; k++) begin
      b = 8'($urandom_range(0, 255));
      push(0, b);
      if (k > 0) model_idle(3);
      model_frame(b, 0);
    end
    model_idle(4);
    tx_en[0] = 1'b1;
    record(0, exp_q.size());
    tx_en[0] = 1'b0;
    mm = first_mismatch();
    checks++; if (mm != -1) begin errors++; $display("FAIL b2b_rand_line: cycle %0d got %b expected %b", mm, act_q[mm], exp_q[mm]); end
    checks++; if (frames[0] !== 16'(3 + cnt)) begin errors++; $display("FAIL b2b_rand_frames: got %0d expected %0d", frames[0], 3 + cnt); end
    checks++; if (busy_cnt != cnt * (2 + 10 * N)) begin errors++; $display("FAIL b2b_rand_busy: got %0d expected %0d", busy_cnt, cnt * (2 + 10 * N)); end
  endtask

  task automatic test_pause();
    int         mm;
    logic [7:0] b1, b2;
    do_reset();
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    push(0, b1);
    push(0, b2);
    clear_rec();
    model_idle(2);
    model_frame(b1, 0);
    model_idle(10);
    tx_en[0] = 1'b1;
    record(0, 2 + 4 * N);
    tx_en[0] = 1'b0;
    record(0, exp_q.size() - act_q.size());
    mm = first_mismatch();
    checks++; if (mm != -1) begin errors++; $display("FAIL pause_line: cycle %0d got %b expected %b", mm, act_q[mm], exp_q[mm]); end
    checks++; if (rd_cnt != 1 || done_cnt != 1) begin errors++; $display("FAIL pause_counts: got pops %0d dones %0d expected 1 1", rd_cnt, done_cnt); end
    checks++; if (busy[0] !== 1'b0 || frames[0] !== 16'd1) begin errors++; $display("FAIL pause_idle: got busy %b frames %0d expected 0 1", busy[0], frames[0]); end
    clear_rec();
    model_idle(2);
    model_frame(b2, 0);
    model_idle(3);
    tx_en[0] = 1'b1;
    record(0, exp_q.size());
    tx_en[0] = 1'b0;
    mm = first_mismatch();
    checks++; if (mm != -1) begin errors++; $display("FAIL pause_resume_line: cycle %0d got %b expected %b", mm, act_q[mm], exp_q[mm]); end
    checks++; if (frames[0] !== 16'd2 || rd_cnt != 1) begin errors++; $display("FAIL pause_resume_counts: got frames %0d pops %0d expected 2 1", frames[0], rd_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int         mm;
    logic [7:0] b;
    do_reset();
    b = 8'($urandom_range(0, 255));
    push(0, b);
    clear_rec();
    tx_en[0] = 1'b1;
    record(0, 2 + 4 * N + 1);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy[0]); end
    rst = 1'b1;
    tx_en[0] = 1'b0;
    tick(1);
    rst = 1'b0;
    checks++; if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin errors++; $display("FAIL midrst_state: got tx %b busy %b expected 1 0", tx[0], busy[0]); end
    checks++; if (frames[0] !== 16'd0 || tx_done[0] !== 1'b0) begin errors++; $display("FAIL midrst_frames: got frames %0d done %b expected 0 0", frames[0], tx_done[0]); end
    clear_rec();
    model_idle(12 * N);
    record(0, exp_q.size());
    mm = first_mismatch();
    checks++; if (mm != -1 || done_cnt != 0 || rd_cnt != 0) begin errors++; $display("FAIL midrst_no_resume: diff cycle %0d dones %0d pops %0d expected -1 0 0", mm, done_cnt, rd_cnt); end

    // Counter wrap: preload the frame counter at its maximum, then send one frame.
    u_none.frames_sent_q = 16'hFFFF;
    tick(1);
    b = 8'($urandom_range(0, 255));
    push(0, b);
    clear_rec();
    model_idle(2);
    model_frame(b, 0);
    model_idle(3);
    tx_en[0] = 1'b1;
    record(0, exp_q.size());
    tx_en[0] = 1'b0;
    mm = first_mismatch();
    checks++; if (mm != -1) begin errors++; $display("FAIL wrap_line: cycle %0d got %b expected %b", mm, act_q[mm], exp_q[mm]); end
    checks++; if (frames[0] !== 16'h0000 || done_cnt != 1) begin errors++; $display("FAIL wrap_frames: got %h dones %0d expected 0000 1", frames[0], done_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_parity();
    test_back_to_back();
    test_pause();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
